// File: rtl/comb.sv
// CIC comb stage: y[n] = x[n] - x[n-M] over valid-qualified signed samples.
// The output is one bit wider than the input, so the difference never wraps.
module comb #(
  parameter int Win = 16,
  parameter int M   = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [Win-1:0] data_in,
  input  logic           val_in,
  output logic           val_out,
  output logic [Win:0]   data_out
);

  // Valid-only stream with no backpressure. data_in is consumed on any edge
  // where val_in is high. val_out follows val_in after one register stage.
  // data_out is meaningful only while val_out is high; otherwise it holds.
  logic [Win-1:0] dly [M];
  logic [Win:0]   diff;

  assign diff = $signed({data_in[Win-1], data_in}) -
                $signed({dly[M-1][Win-1], dly[M-1]});

  always_ff @(posedge clk) begin
    if (rst) begin
      val_out  <= 1'b0;
      data_out <= '0;
      for (int k = 0; k < M; k++) dly[k] <= '0;
    end else begin
      val_out <= val_in;
      if (val_in) begin
        data_out <= diff;
        dly[0]   <= data_in;
        // Idle cycles leave the history untouched, so gaps are transparent.
        for (int k = 1; k < M; k++) dly[k] <= dly[k-1];
      end
    end
  end

endmodule

// File: tb/tb_comb.sv
// Directed bench for comb: one instance with M=1 and one with M=2,
// driven 1 ns after the rising edge and checked 1 ns after the next one.
module tb_comb;

  logic        clk;
  logic        rst;
  logic [15:0] d1, d2;
  logic        v1, v2;
  logic        vo1, vo2;
  logic [16:0] do1, do2;

  int n_checks = 0;
  int n_fail   = 0;

  comb #(.Win(16), .M(1)) u1 (
    .clk(clk), .rst(rst), .data_in(d1), .val_in(v1),
    .val_out(vo1), .data_out(do1)
  );

  comb #(.Win(16), .M(2)) u2 (
    .clk(clk), .rst(rst), .data_in(d2), .val_in(v2),
    .val_out(vo2), .data_out(do2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, pass one rising edge, land 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic [15:0] d, input logic v);
    d1 = d; v1 = v; d2 = '0; v2 = 1'b0;
    tick();
  endtask

  task automatic step2(input logic [15:0] d, input logic v);
    d2 = d; v2 = v; d1 = '0; v1 = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; d1 = 16'h7fff; v1 = 1'b1; d2 = 16'h7fff; v2 = 1'b1;
    tick();
    check("rst_val1", {16'h0, vo1}, 17'h0);
    check("rst_dat1", do1, 17'h0);
    check("rst_val2", {16'h0, vo2}, 17'h0);
    check("rst_dat2", do2, 17'h0);
    rst = 1'b0;
  endtask

  logic [15:0] prev;
  logic [15:0] cur;
  logic        vv;
  logic [16:0] hold;

  initial begin
    rst = 1'b1; d1 = 16'h1234; v1 = 1'b1; d2 = 16'h1234; v2 = 1'b1;
    #1;

    // Reset held with valid data present: reset must win every cycle.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset_hold_val", {16'h0, vo1}, 17'h0);
      check("reset_hold_dat", do1, 17'h0);
    end
    rst = 1'b0;
    step1(16'h1234, 1'b1);
    check("first_val", {16'h0, vo1}, 17'h1);
    check("first_dat", do1, 17'h01234);

    // Impulse, M=1
    do_reset();
    step1(16'd5, 1'b1); check("imp0", do1, 17'h00005);
    step1(16'd0, 1'b1); check("imp1", do1, 17'h1fffb);
    step1(16'd0, 1'b1); check("imp2", do1, 17'h00000);
    check("imp_val", {16'h0, vo1}, 17'h1);

    // Step, M=2
    do_reset();
    step2(16'd100, 1'b1); check("step0", do2, 17'd100);
    step2(16'd100, 1'b1); check("step1", do2, 17'd100);
    step2(16'd100, 1'b1); check("step2", do2, 17'd0);
    step2(16'd100, 1'b1); check("step3", do2, 17'd0);

    // M=2 with a gap: history skips the idle cycle.
    do_reset();
    step2(16'd7,  1'b1); check("g2_0", do2, 17'd7);
    step2(16'd9,  1'b1); check("g2_1", do2, 17'd9);
    step2(16'd1,  1'b0); check("g2_hold", do2, 17'd9);
    check("g2_val", {16'h0, vo2}, 17'h0);
    step2(16'd20, 1'b1); check("g2_2", do2, 17'd13);

    // Extremes, M=1
    do_reset();
    step1(16'h8000, 1'b1); check("ext0", do1, 17'h18000);
    step1(16'h7fff, 1'b1); check("ext1", do1, 17'h0ffff);
    step1(16'h8000, 1'b1); check("ext2", do1, 17'h10001);

    // Gapped valid, M=1
    do_reset();
    step1(16'd10,   1'b1); check("gap_v0", {16'h0, vo1}, 17'h1); check("gap_d0", do1, 17'd10);
    step1(16'haaaa, 1'b0); check("gap_v1", {16'h0, vo1}, 17'h0); check("gap_d1", do1, 17'd10);
    step1(16'h5555, 1'b0); check("gap_v2", {16'h0, vo1}, 17'h0); check("gap_d2", do1, 17'd10);
    step1(16'd25,   1'b1); check("gap_v3", {16'h0, vo1}, 17'h1); check("gap_d3", do1, 17'd15);

    // Reset mid-stream: history is lost, restart is a fresh start-up.
    step1(16'd40, 1'b1);
    do_reset();
    step1(16'd3, 1'b1); check("restart", do1, 17'd3);

    // Random stream with random gaps, M=1, expected x[n] - x[n-1].
    do_reset();
    prev = '0; hold = '0;
    for (int i = 0; i < 40; i++) begin
      cur = 16'($urandom_range(0, 65535));
      vv  = ($urandom_range(0, 3) != 0);
      step1(cur, vv);
      if (vv) begin
        hold = $signed({cur[15], cur}) - $signed({prev[15], prev});
        prev = cur;
      end
      check("rand_val", {16'h0, vo1}, {16'h0, vv});
      check("rand_dat", do1, hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
